// File: rtl/mic_pkg.sv
// Shared types and defaults for the PDM microphone capture path.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mic_pkg;

    localparam int MIC_DIV_HALF_DEF = 25;
    localparam int MIC_FIFO_DEPTH   = 200000;
    localparam int MIC_CNT_W        = 20;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        RECORD,
        DONE
    } state_t;

endpackage

// File: rtl/pdm_clk_gen.sv
// Divides Clk down to the PDM mic clock and flags the cycle before each falling edge.
// Latency: mic_clk toggles on the edge after terminal count; sample_evt is combinational from registers.
// Backpressure: none; gate=0 parks the divider and holds mic_clk low, clr restarts the count.
module pdm_clk_gen #(
    parameter int DIV_HALF = 25
) (
    input  logic Clk,
    input  logic RstN,
    input  logic gate,
    input  logic clr,
    output logic mic_clk,
    output logic sample_evt
);

    localparam int            DW = $clog2(DIV_HALF);
    localparam logic [DW-1:0] TC = DW'(DIV_HALF - 1);

    logic [DW-1:0] div;
    logic          tc;

    assign tc = (div == TC);

    // Last cycle of the high phase: mic data is stable here.
    assign sample_evt = tc && mic_clk && gate;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            div     <= '0;
            mic_clk <= 1'b0;
        end else if (!gate) begin
            div     <= '0;
            mic_clk <= 1'b0;
        end else if (clr) begin
            div     <= '0;
        end else if (tc) begin
            div     <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div     <= div + 1'b1;
        end
    end

endmodule

// File: rtl/pdm_mic_capture.sv
// Records one PDM mic bit per mic clock into the record FIFO per session (build option MIC_CLK_GATE_EN gates the mic clock).
// Latency: write strobe and data appear the cycle after the sample event; the first sample is skipped for alignment.
// Backpressure: F_FullN low at a sample event ends the session with no write; Abort ends it next cycle.
module pdm_mic_capture
    import mic_pkg::*;
#(
    parameter int DIV_HALF    = MIC_DIV_HALF_DEF,
    parameter int MAX_SAMPLES = MIC_FIFO_DEPTH,
    parameter int CNT_W       = MIC_CNT_W
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Mic_Data,
    output logic             Mic_Clk,
    output logic             Mic_LRSel,
    output logic             Data_Out,
    output logic             FInN,
    output logic             FClrN,
    input  logic             F_FullN,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Sample_Cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             sync2;
    logic             sample_evt;
    logic             wr;
    logic             gate;
    logic             clr;
    logic [CNT_W-1:0] cnt_inc;

    assign Mic_LRSel = 1'b0;
    assign cnt_inc   = Sample_Cnt + 1'b1;

`ifdef MIC_CLK_GATE_EN
    assign gate = Busy;
    assign clr  = (state == CLEAR);
`else
    assign gate = 1'b1;
    assign clr  = 1'b0;
`endif

    pdm_clk_gen #(
        .DIV_HALF   (DIV_HALF)
    ) u_clk_gen (
        .Clk        (Clk),
        .RstN       (RstN),
        .gate       (gate),
        .clr        (clr),
        .mic_clk    (Mic_Clk),
        .sample_evt (sample_evt)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Mic_Data;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = Abort ? DONE : ARM;
            end
            ARM: begin
                if (Abort) begin
                    state_nxt = DONE;
                end else if (sample_evt) begin
                    state_nxt = RECORD;
                end
            end
            RECORD: begin
                if (Abort) begin
                    state_nxt = DONE;
                end else if (sample_evt) begin
                    if (F_FullN) begin
                        wr = 1'b1;
                        if (cnt_inc == MAX_CNT) begin
                            state_nxt = DONE;
                        end
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Data_Out   <= 1'b0;
            FInN       <= 1'b1;
            FClrN      <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Sample_Cnt <= '0;
        end else begin
            FInN  <= ~wr;
            FClrN <= (state_nxt != CLEAR);
            Busy  <= (state_nxt == CLEAR) || (state_nxt == ARM) || (state_nxt == RECORD);
            Done  <= (state_nxt == DONE);
            if (wr) begin
                Data_Out   <= sync2;
                Sample_Cnt <= cnt_inc;
            end else if (state_nxt == CLEAR) begin
                Sample_Cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture: session table plus hand-written reset, idle and period sequences.
module tb_pdm_mic_capture;

    localparam int DIV_HALF = 25;
    localparam int MAXS     = 8;
    localparam int CNT_W    = 20;

    typedef enum int {P_NONE, P_FULL, P_ABORT, P_RESTART} poke_t;
    typedef struct {
        logic [7:0] pat;
        poke_t      kind;
        int         at;
        int         exp_wr;
        int         gap;
    } vec_t;

    logic             Clk;
    logic             RstN;
    logic             Start;
    logic             Abort;
    logic             Mic_Data = 1'b0;
    logic             F_FullN;
    logic             Mic_Clk;
    logic             Mic_LRSel;
    logic             Data_Out;
    logic             FInN;
    logic             FClrN;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Sample_Cnt;

    int vectors     = 0;
    int miscompares = 0;

    int  cyc          = 0;
    int  wr_total     = 0;
    int  done_total   = 0;
    int  fclr_total   = 0;
    int  sess_wr      = 0;
    int  last_wr_cyc  = 0;
    int  done_cyc     = 0;
    bit  prev_fin_low = 1'b0;
    bit  prev_mc      = 1'b0;
    bit  active       = 1'b0;
    int  idx          = 0;
    bit  exp_q[$];
    logic [7:0] cur_pat = 8'h00;

    vec_t tbl[5];

    pdm_mic_capture #(
        .DIV_HALF    (DIV_HALF),
        .MAX_SAMPLES (MAXS),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .Start      (Start),
        .Abort      (Abort),
        .Mic_Data   (Mic_Data),
        .Mic_Clk    (Mic_Clk),
        .Mic_LRSel  (Mic_LRSel),
        .Data_Out   (Data_Out),
        .FInN       (FInN),
        .FClrN      (FClrN),
        .F_FullN    (F_FullN),
        .Busy       (Busy),
        .Done       (Done),
        .Sample_Cnt (Sample_Cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard and mic data driver share one process so queue order is fixed.
    always @(negedge Clk) begin
        cyc++;
        if (!FInN) begin
            check("fin_pulse_width", prev_fin_low, 0);
            wr_total++;
            sess_wr++;
            check("write_has_expect", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("data_out", Data_Out, exp_q.pop_front());
            end
            check("sample_cnt_at_write", Sample_Cnt, sess_wr);
            if (sess_wr > 1) begin
                check("write_spacing", cyc - last_wr_cyc, 2 * DIV_HALF);
            end
            last_wr_cyc = cyc;
        end
        prev_fin_low = !FInN;
        if (Done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (!FClrN) begin
            fclr_total++;
            sess_wr = 0;
            idx     = 0;
            active  = 1'b1;
            exp_q.delete();
        end
        if (!RstN) begin
            active = 1'b0;
        end
        if (active && prev_mc && !Mic_Clk) begin
            if (!Busy || idx >= 8) begin
                active = 1'b0;
            end else begin
                Mic_Data = cur_pat[idx];
                exp_q.push_back(cur_pat[idx]);
                idx++;
            end
        end
        prev_mc = Mic_Clk;
    end

    task automatic wait_mic_level(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Mic_Clk == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_mic_rise(output bit ok);
        bit ok0;
        bit ok1;
        wait_mic_level(1'b0, ok0);
        wait_mic_level(1'b1, ok1);
        ok = ok0 && ok1;
    endtask

    task automatic wait_writes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            #1;
            if (wr_total >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int dn0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            #1;
            if (done_total > dn0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic run_session(input int k);
        int wr0;
        int dn0;
        int cl0;
        bit ok;
        cur_pat = tbl[k].pat;
        wr0 = wr_total;
        dn0 = done_total;
        cl0 = fclr_total;
        wait_mic_rise(ok);
        check("timeout_mic_rise", ok, 1);
        pulse_start();
        if (tbl[k].kind != P_NONE) begin
            wait_writes(wr0 + tbl[k].at, ok);
            check("timeout_writes", ok, 1);
            case (tbl[k].kind)
                P_FULL: F_FullN = 1'b0;
                P_ABORT: begin
                    // Land Abort exactly on the next sample event.
                    repeat (2 * DIV_HALF - 1) @(posedge Clk);
                    #1 Abort = 1'b1;
                    @(posedge Clk);
                    #1 Abort = 1'b0;
                    @(negedge Clk);
                    check("abort_done_next", Done, 1);
                end
                P_RESTART: pulse_start();
                default: ;
            endcase
        end
        wait_done(dn0, ok);
        check("timeout_done", ok, 1);
        repeat (3 * DIV_HALF) @(negedge Clk);
        F_FullN = 1'b1;
        check("writes", wr_total - wr0, tbl[k].exp_wr);
        check("sample_cnt_final", Sample_Cnt, tbl[k].exp_wr);
        check("done_pulses", done_total - dn0, 1);
        check("fclr_cycles", fclr_total - cl0, 1);
        check("busy_after", Busy, 0);
        check("done_gap", done_cyc - last_wr_cyc, tbl[k].gap);
    endtask

    initial begin
        bit ok;
        int hi;
        int lo;
        int seen;
        int wr0;
        int cl0;
        int dn0;

        tbl[0] = '{8'h4D, P_NONE,    0, 8, 0};
        tbl[1] = '{8'h5A, P_FULL,    3, 3, 2 * DIV_HALF};
        tbl[2] = '{8'hC3, P_ABORT,   5, 5, 2 * DIV_HALF};
        tbl[3] = '{8'hB2, P_RESTART, 2, 8, 0};
        tbl[4] = '{8'h96, P_NONE,    0, 8, 0};

        RstN    = 1'b0;
        Start   = 1'b0;
        Abort   = 1'b0;
        F_FullN = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst_mic_clk",  Mic_Clk, 0);
        check("rst_lrsel",    Mic_LRSel, 0);
        check("rst_data_out", Data_Out, 0);
        check("rst_fin_n",    FInN, 1);
        check("rst_fclr_n",   FClrN, 1);
        check("rst_busy",     Busy, 0);
        check("rst_done",     Done, 0);
        check("rst_cnt",      Sample_Cnt, 0);
        @(posedge Clk);
        #1 RstN = 1'b1;

        wr0 = wr_total;
        cl0 = fclr_total;
        wait_mic_rise(ok);
        check("timeout_period_rise", ok, 1);
        hi = 1;
        lo = 0;
        for (int i = 0; i < 200 && Mic_Clk; i++) begin
            @(negedge Clk);
            if (Mic_Clk) hi++;
        end
        for (int i = 0; i < 200 && !Mic_Clk; i++) begin
            lo++;
            @(negedge Clk);
        end
        check("mic_clk_high", hi, DIV_HALF);
        check("mic_clk_low",  lo, DIV_HALF);
        repeat (120) @(negedge Clk);
        check("idle_no_writes", wr_total - wr0, 0);
        check("idle_no_clear",  fclr_total - cl0, 0);

        for (int k = 0; k < 4; k++) begin
            run_session(k);
        end

        cl0 = fclr_total;
        dn0 = done_total;
        @(negedge Clk);
        Start = 1'b1;
        Abort = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        Abort = 1'b0;
        repeat (5) @(negedge Clk);
        check("start_abort_busy",  Busy, 0);
        check("start_abort_fclr",  fclr_total - cl0, 0);
        check("start_abort_done",  done_total - dn0, 0);

        cur_pat = 8'h69;
        wait_mic_rise(ok);
        check("timeout_rst_rise", ok, 1);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 1500 && seen < 2; i++) begin
            @(negedge Clk);
            if (!FInN) seen++;
        end
        check("timeout_rst_writes", seen, 2);
        #2 RstN = 1'b0;
        #1;
        check("midrst_fin_n",   FInN, 1);
        check("midrst_busy",    Busy, 0);
        check("midrst_mic_clk", Mic_Clk, 0);
        check("midrst_cnt",     Sample_Cnt, 0);
        repeat (3) @(posedge Clk);
        #1 RstN = 1'b1;
        run_session(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
